uart_transceiver: RTL and testbench

- Full-duplex 8N1 UART byte transceiver: one transmitter and one receiver sharing a clock, reset and bit-timing parameter.
- Used by the host-side loader/server and by the CPU top to exchange program size, instruction words, data words and result bytes over a serial link.
- Byte-level handshake only; word packing and framing protocol are done by the caller.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_transceiver.sv | 169 ++++++++++++++++
 tb/tb_uart_transceiver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
package uart_pkg;
    localparam int   DATA_BITS   = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tick is high while the count sits at zero.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART byte transceiver with independent TX and RX FSMs.
// Optional macro UART_LOOPBACK_EN feeds the receiver from the internal txd and parks the txd pin high.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLOCK_PER_HALF_BIT = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] sdata,
    output logic                 tx_busy,
    output logic                 txd,
    input  logic                 rxd_orig,
    output logic                 rx_ready,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 ferr
);
    localparam int BIT_CYC = 2 * CLOCK_PER_HALF_BIT;
    localparam int TW      = $clog2(BIT_CYC);
    localparam int BW      = $clog2(DATA_BITS);
    localparam logic [TW-1:0] FULL_LOAD = TW'(BIT_CYC - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLOCK_PER_HALF_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic                 tx_load, tx_tick, tx_accept, txd_int;

    // Busy covers the accept cycle too, so a caller never double-sends.
    assign tx_accept = tx_start && (tx_state_q == TX_IDLE);
    assign tx_busy   = (tx_state_q != TX_IDLE) || tx_accept;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_load    = 1'b0;
        txd_int    = STOP_LEVEL;
        case (tx_state_q)
            TX_IDLE: if (tx_start) begin
                tx_state_d = TX_START;
                tx_shift_d = sdata;
                tx_load    = 1'b1;
            end
            TX_START: begin
                txd_int = START_LEVEL;
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_load    = 1'b1;
                end
            end
            TX_DATA: begin
                txd_int = tx_shift_q[0];
                if (tx_tick) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_load    = 1'b1;
                    if (tx_bit_q == LAST_BIT) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: if (tx_tick) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    uart_bit_timer #(.W(TW)) u_tx_timer (
        .clock(clock), .reset(reset), .load(tx_load), .load_val(FULL_LOAD), .tick(tx_tick)
    );

    // ---------------- receiver ----------------
    rx_state_e            rx_state_q, rx_state_d;
    logic [1:0]           sync_q, sync_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rdata_q, rdata_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic                 rx_ready_q, rx_ready_d, ferr_q, ferr_d;
    logic                 rx_load, rx_tick, rxd_s;
    logic [TW-1:0]        rx_load_val;

    assign sync_d = {sync_q[0], rxd_orig};

`ifdef UART_LOOPBACK_EN
    logic unused_sync;
    assign unused_sync = sync_q[1];
    assign rxd_s = txd_int;
    assign txd   = 1'b1;
`else
    assign rxd_s = sync_q[1];
    assign txd   = txd_int;
`endif

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_bit_d    = rx_bit_q;
        rdata_d     = rdata_q;
        ferr_d      = ferr_q;
        rx_ready_d  = 1'b0;
        rx_load     = 1'b0;
        rx_load_val = FULL_LOAD;
        case (rx_state_q)
            RX_IDLE: if (rxd_s == START_LEVEL) begin
                rx_state_d  = RX_START;
                rx_load     = 1'b1;
                rx_load_val = HALF_LOAD;
            end
            // A start bit that is gone by mid-bit is treated as a glitch.
            RX_START: if (rx_tick) begin
                if (rxd_s != START_LEVEL) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = '0;
                    rx_load    = 1'b1;
                end
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_d = {rxd_s, rx_shift_q[DATA_BITS-1:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                rx_load    = 1'b1;
                if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_tick) begin
                rx_state_d = RX_IDLE;
                rdata_d    = rx_shift_q;
                ferr_d     = (rxd_s != STOP_LEVEL);
                rx_ready_d = 1'b1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    uart_bit_timer #(.W(TW)) u_rx_timer (
        .clock(clock), .reset(reset), .load(rx_load), .load_val(rx_load_val), .tick(rx_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            rx_state_q <= RX_IDLE;
            sync_q     <= 2'b11;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rdata_q    <= '0;
            ferr_q     <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            rx_state_q <= rx_state_d;
            sync_q     <= sync_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rdata_q    <= rdata_d;
            ferr_q     <= ferr_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign rdata    = rdata_q;
    assign ferr     = ferr_q;
endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench: frame-timing model compared every cycle plus directed literal checks.
module tb_uart_transceiver;
    localparam int H   = 10;
    localparam int BIT = 2 * H;
    localparam int FRM = 10 * BIT;

    logic       clock = 1'b0, reset = 1'b1, tx_start = 1'b0, rxd_drv = 1'b1, loop_en = 1'b0;
    logic [7:0] sdata = 8'h00;
    logic       tx_busy, txd, rx_ready, ferr, rxd_orig;
    logic [7:0] rdata;

    assign rxd_orig = loop_en ? txd : rxd_drv;

    uart_transceiver #(.CLOCK_PER_HALF_BIT(H)) dut (
        .clock(clock), .reset(reset), .tx_start(tx_start), .sdata(sdata),
        .tx_busy(tx_busy), .txd(txd), .rxd_orig(rxd_orig),
        .rx_ready(rx_ready), .rdata(rdata), .ferr(ferr)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    int n_checks = 0, n_fail = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a frame accepted at cycle t0 drives bit k during cycles t0+1+k*BIT .. t0+(k+1)*BIT;
    // a frame whose start edge reaches rxd_orig at cycle s is reported at cycle s+19H+3.
    typedef struct { int at; logic [7:0] d; logic fe; } rx_ev_t;
    rx_ev_t     rx_q[$];
    logic [7:0] rx_log[$];
    logic       fe_log[$];
    bit         armed = 0, tx_act = 0;
    int         t0 = 0, rx_pulses = 0;
    logic [7:0] tx_d = 8'h00, exp_rdata = 8'h00;
    logic       exp_ferr = 1'b0;

    always @(negedge clock) begin
        bit busy_prev, exp_busy, exp_txd, exp_rdy;
        int k;
        busy_prev = tx_act && (cyc <= t0 + FRM);
        if (tx_start && !busy_prev) begin
            tx_act = 1; t0 = cyc; tx_d = sdata;
            if (loop_en) rx_q.push_back('{t0 + 19*H + 4, sdata, 1'b0});
        end
        exp_busy = tx_act && cyc >= t0 && cyc <= t0 + FRM;
        exp_txd  = 1'b1;
        if (tx_act && cyc > t0 && cyc <= t0 + FRM) begin
            k = (cyc - t0 - 1) / BIT;
            exp_txd = (k == 0) ? 1'b0 : (k <= 8) ? tx_d[k-1] : 1'b1;
        end
        exp_rdy = (rx_q.size() > 0) && (rx_q[0].at == cyc);
        if (exp_rdy) begin
            exp_rdata = rx_q[0].d; exp_ferr = rx_q[0].fe; void'(rx_q.pop_front());
        end
        if (armed) begin
            chk("m_txd", txd, exp_txd);
            chk("m_tx_busy", tx_busy, exp_busy);
            chk("m_rx_ready", rx_ready, exp_rdy);
            chk("m_rdata", rdata, exp_rdata);
            chk("m_ferr", ferr, exp_ferr);
        end
        if (rx_ready === 1'b1) begin
            rx_pulses++; rx_log.push_back(rdata); fe_log.push_back(ferr);
        end
        if (reset) begin
            armed = 1; tx_act = 0; rx_q.delete(); exp_rdata = 8'h00; exp_ferr = 1'b0;
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(logic [7:0] d, logic stop);
        step();
        rxd_drv = 1'b0;
        rx_q.push_back('{cyc + 19*H + 3, d, ~stop});
        step(BIT);
        for (int i = 0; i < 8; i++) begin rxd_drv = d[i]; step(BIT); end
        rxd_drv = stop;
        step(BIT);
        rxd_drv = 1'b1;
    endtask

    task automatic check_frame(string name, int ts, logic [9:0] frame);
        for (int k = 0; k < 10; k++) begin
            step(ts + 1 + k*BIT + H - cyc);
            chk(name, txd, frame[k]);
        end
    endtask

    initial begin
        int ts, n, b0;
        logic [9:0] f_a5, f_5a;
        f_a5 = 10'b1_10100101_0;
        f_5a = 10'b1_01011010_0;

        // Reset and idle
        step(3); reset = 1'b0;
        step(100);
        chk("idle_txd", txd, 1'b1);
        chk("idle_busy", tx_busy, 1'b0);
        chk("idle_no_rx", rx_pulses, 0);
        chk("idle_rdata", rdata, 8'h00);

        // Single 0xA5 frame, sdata changed after accept
        step(); tx_start = 1'b1; sdata = 8'hA5; ts = cyc;
        #1 chk("busy_accept", tx_busy, 1'b1);
        step(); tx_start = 1'b0; sdata = 8'h3F;
        check_frame("a5_bit", ts, f_a5);
        step(ts + FRM - cyc);
        chk("busy_last", tx_busy, 1'b1);
        step();
        chk("busy_fall", tx_busy, 1'b0);

        // Loopback, back-to-back 0x99 then 0xAA
        step(5); loop_en = 1'b1; b0 = rx_log.size();
        step(); tx_start = 1'b1; sdata = 8'h99;
        step(); tx_start = 1'b0;
        n = 0;
        while (tx_busy && n < 400) begin step(); n++; end
        chk("b2b_wait_bound", n < 400, 1'b1);
        tx_start = 1'b1; sdata = 8'hAA;
        step(); tx_start = 1'b0;
        step(250);
        chk("lb_count", rx_log.size(), b0 + 2);
        if (rx_log.size() >= b0 + 2) begin
            chk("lb_first", rx_log[b0], 8'h99);
            chk("lb_second", rx_log[b0+1], 8'hAA);
            chk("lb_ferr", {fe_log[b0], fe_log[b0+1]}, 2'b00);
        end
        chk("lb_idle_busy", tx_busy, 1'b0);
        loop_en = 1'b0;

        // Framing error then good frame
        step(20); b0 = rx_log.size();
        send_frame(8'h3C, 1'b0);
        step(40);
        send_frame(8'h01, 1'b1);
        step(40);
        chk("fe_count", rx_log.size(), b0 + 2);
        if (rx_log.size() >= b0 + 2) begin
            chk("fe_data", rx_log[b0], 8'h3C);
            chk("fe_flag", fe_log[b0], 1'b1);
            chk("good_data", rx_log[b0+1], 8'h01);
            chk("good_flag", fe_log[b0+1], 1'b0);
        end

        // Short glitch on idle line
        b0 = rx_log.size();
        step(); rxd_drv = 1'b0;
        step(5); rxd_drv = 1'b1;
        step(60);
        chk("glitch_count", rx_log.size(), b0);
        chk("glitch_rdata", rdata, 8'h01);
        chk("glitch_ferr", ferr, 1'b0);

        // Reset mid-transmission of 0xFF, then a fresh frame
        step(); tx_start = 1'b1; sdata = 8'hFF;
        step(); tx_start = 1'b0;
        step(50);
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        step(5); tx_start = 1'b1; sdata = 8'h5A; ts = cyc;
        step(); tx_start = 1'b0;
        check_frame("5a_bit", ts, f_5a);
        step(ts + FRM + 1 - cyc);
        chk("5a_busy_fall", tx_busy, 1'b0);

        step(20);
        chk("rx_q_drained", rx_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
